// File: rtl/sort_stream.sv
// sort_stream: collects a frame of N words over a valid/ready input and
// sorts it in place with an N-pass odd-even transposition network. It then
// streams the sorted frame out over a valid/ready output, with a last marker
// on the final word. Frames do not overlap: LOAD -> SORT -> DRAIN -> LOAD.
module sort_stream #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int DESCEND = 0,
  parameter int SIGNED  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  localparam int CW = $clog2(N) + 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  // Flipping the MSB maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = (SIGNED != 0) ? (ONE << (WIDTH - 1)) : '0;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state_q;
  logic [CW-1:0]    idx_q;
  logic [CW-1:0]    pass_q;
  logic [WIDTH-1:0] arr_q    [N];
  logic [WIDTH-1:0] sorted_d [N];
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic             busy_q;

  logic [CW-1:0]    idx_inc;
  assign idx_inc = idx_q + CW'(1);

  // True when a must move after b in the requested order. Equal words never
  // swap, which keeps the sort stable.
  function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ka;
    logic [WIDTH-1:0] kb;
    ka = a ^ MSB_MASK;
    kb = b ^ MSB_MASK;
    return (DESCEND != 0) ? (ka < kb) : (ka > kb);
  endfunction

  // One transposition pass: even passes pair (0,1),(2,3)..., odd passes
  // pair (1,2),(3,4)...; pairs never overlap so all swaps are independent.
  always_comb begin
    // NOTE: the default copy first means every element is assigned on every
    // path, so no latch is inferred for the elements no pair touches.
    sorted_d = arr_q;
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(pass_q[0]) && out_of_order(arr_q[i], arr_q[i+1])) begin
        sorted_d[i]   = arr_q[i+1];
        sorted_d[i+1] = arr_q[i];
      end
    end
  end

  // Frame FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      pass_q      <= '0;
      // NOTE: the word array is cleared on reset so a frame aborted by reset
      // leaves no residue; it is small enough to live in flops, not a RAM.
      for (int i = 0; i < N; i++) arr_q[i] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the state from before this edge regardless of statement order.
      case (state_q)
        LOAD: begin
          if (in_valid_i) begin
            arr_q[idx_q[AW-1:0]] <= in_data_i;
            if (idx_q == LAST) begin
              idx_q      <= '0;
              pass_q     <= '0;
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        SORT: begin
          arr_q  <= sorted_d;
          pass_q <= pass_q + CW'(1);
          if (pass_q == LAST) begin
            state_q     <= DRAIN;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= sorted_d[0];
            out_last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (idx_q == LAST) begin
              state_q     <= LOAD;
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              idx_q      <= idx_inc;
              out_data_q <= arr_q[idx_inc[AW-1:0]];
              out_last_q <= (idx_inc == LAST);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_sort_stream.sv
// Testbench for sort_stream: four instances with different parameters
// (default, N=8, odd N=5, descending signed), checked against a stable
// insertion-sort reference model.
module tb_sort_stream;

  localparam int NI = 4;
  localparam int NS [NI] = '{4, 8, 5, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid    [NI];
  logic [7:0] in_data     [NI];
  logic       out_ready   [NI];
  logic       in_ready_w  [NI];
  logic       out_valid_w [NI];
  logic [7:0] out_data_w  [NI];
  logic       out_last_w  [NI];
  logic       busy_w      [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sort_stream #(
      .WIDTH  (8),
      .N      (NS[g]),
      .DESCEND((g == 3) ? 1 : 0),
      .SIGNED ((g == 3) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (in_valid[g]),
      .in_data_i  (in_data[g]),
      .in_ready_o (in_ready_w[g]),
      .out_valid_o(out_valid_w[g]),
      .out_data_o (out_data_w[g]),
      .out_last_o (out_last_w[g]),
      .out_ready_i(out_ready[g]),
      .busy_o     (busy_w[g])
    );
  end

  // Reference: order key of a raw 8-bit word.
  function automatic int key_of(input int v, input bit sgn);
    return (sgn && v >= 128) ? v - 256 : v;
  endfunction

  // Reference: stable insertion sort (a new word goes after every word it
  // does not strictly precede).
  function automatic void ref_sort(input int vals[$], input bit desc, input bit sgn,
                                   output int res[$]);
    res = {};
    foreach (vals[i]) begin
      int p;
      int kn;
      p  = res.size();
      kn = key_of(vals[i], sgn);
      while (p > 0 && (desc ? kn > key_of(res[p-1], sgn) : kn < key_of(res[p-1], sgn)))
        p--;
      res.insert(p, vals[i]);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers each word until accepted; reports the cycle of the first and
  // last accept.
  task automatic load_frame(input int k, input int vals[$],
                            output int first_cyc, output int last_cyc, output int timeouts);
    timeouts = 0;
    first_cyc = 0;
    last_cyc = 0;
    for (int i = 0; i < vals.size(); i++) begin
      int budget;
      budget = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = 8'(vals[i]);
      while (!in_ready_w[k] && budget < 50) begin
        step();
        budget++;
      end
      if (!in_ready_w[k]) timeouts++;
      step();
      if (i == 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    in_valid[k] = 1'b0;
  endtask

  // Collects n output words; optionally random out_ready and junk input.
  task automatic drain(input int k, input int n, input bit rand_rdy, input bit junk,
                       output int got[$], output int lasts[$],
                       output int first_valid_cyc, output int last_xfer_cyc,
                       output int stall_errs, output int ready_errs, output int busy_errs,
                       output logic end_ready, output logic end_valid);
    int budget;
    bit stalled;
    logic [7:0] held;
    got = {};
    lasts = {};
    budget = 0;
    stalled = 0;
    held = '0;
    first_valid_cyc = -1;
    last_xfer_cyc = -1;
    stall_errs = 0;
    ready_errs = 0;
    busy_errs = 0;
    while (got.size() < n && budget < 400) begin
      if (out_valid_w[k] && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled && (out_data_w[k] !== held || out_valid_w[k] !== 1'b1)) stall_errs++;
      if (in_ready_w[k] !== 1'b0) ready_errs++;
      if (busy_w[k] !== 1'b1) busy_errs++;
      if (junk) begin
        in_valid[k] = 1'b1;
        in_data[k]  = 8'($urandom);
      end
      out_ready[k] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = out_valid_w[k] && !out_ready[k];
      held = out_data_w[k];
      if (out_valid_w[k] && out_ready[k]) begin
        got.push_back(int'(out_data_w[k]));
        lasts.push_back(int'(out_last_w[k]));
      end
      step();
      budget++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    last_xfer_cyc = cyc;
    end_ready = in_ready_w[k];
    end_valid = out_valid_w[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      out_ready[k] = 1'b0;
    end
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (in_ready_w[k] !== 1'b1 || out_valid_w[k] !== 1'b0 || out_last_w[k] !== 1'b0 ||
          out_data_w[k] !== 8'h00 || busy_w[k] !== 1'b0)
        begin errors++; $display("FAIL reset_values[%0d]: got rdy=%b vld=%b last=%b data=%0d busy=%b expected 1 0 0 0 0",
          k, in_ready_w[k], out_valid_w[k], out_last_w[k], out_data_w[k], busy_w[k]); end
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (in_ready_w[k] !== 1'b1)
        begin errors++; $display("FAIL ready_after_reset[%0d]: got %b expected 1", k, in_ready_w[k]); end
    end
  endtask

  // Loads vals into instance k, drains it, and compares against the model.
  task automatic run_frame(input string name, input int k, input int vals[$],
                           input bit rand_rdy, input bit junk,
                           output int first_acc, output int last_acc,
                           output int first_valid, output int last_xfer);
    int exp[$];
    int got[$];
    int lasts[$];
    int tmo, se, re, be;
    logic er, ev;
    ref_sort(vals, k == 3, k == 3, exp);
    load_frame(k, vals, first_acc, last_acc, tmo);
    checks++;
    if (tmo !== 0) begin errors++; $display("FAIL %s_load_timeout: got %0d expected 0", name, tmo); end
    drain(k, vals.size(), rand_rdy, junk, got, lasts, first_valid, last_xfer, se, re, be, er, ev);
    checks++;
    if (got.size() !== exp.size())
      begin errors++; $display("FAIL %s_count: got %0d words expected %0d", name, got.size(), exp.size()); end
    foreach (exp[i]) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i])
        begin errors++; $display("FAIL %s_word%0d: got %0d expected %0d", name, i,
          (i < got.size()) ? got[i] : -1, exp[i]); end
    end
    foreach (lasts[i]) begin
      checks++;
      if (lasts[i] !== ((i == vals.size() - 1) ? 1 : 0))
        begin errors++; $display("FAIL %s_last%0d: got %0d expected %0d", name, i, lasts[i],
          (i == vals.size() - 1) ? 1 : 0); end
    end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL %s_stall_stable: got %0d violations expected 0", name, se); end
    checks++;
    if (re !== 0) begin errors++; $display("FAIL %s_in_ready_low: got %0d violations expected 0", name, re); end
    checks++;
    if (be !== 0) begin errors++; $display("FAIL %s_busy_high: got %0d violations expected 0", name, be); end
    checks++;
    if (er !== 1'b1 || ev !== 1'b0)
      begin errors++; $display("FAIL %s_after_last: got rdy=%b vld=%b expected rdy=1 vld=0", name, er, ev); end
  endtask

  task automatic test_basic();
    int fa, la, fv, lx;
    run_frame("basic", 0, '{9, 3, 7, 1}, 1'b0, 1'b0, fa, la, fv, lx);
    checks++;
    if (fv - la !== 4)
      begin errors++; $display("FAIL basic_latency: got %0d cycles expected 4", fv - la); end
  endtask

  task automatic test_reverse8();
    int fa, la, fv, lx;
    run_frame("rev8", 1, '{255, 254, 253, 252, 251, 250, 249, 248}, 1'b0, 1'b0, fa, la, fv, lx);
    checks++;
    if (lx - fa + 1 !== 24)
      begin errors++; $display("FAIL rev8_frame_cycles: got %0d expected 24", lx - fa + 1); end
  endtask

  task automatic test_odd5();
    int fa, la, fv, lx;
    run_frame("odd5", 2, '{4, 4, 2, 9, 2}, 1'b0, 1'b0, fa, la, fv, lx);
    checks++;
    if (fv - la !== 5)
      begin errors++; $display("FAIL odd5_latency: got %0d cycles expected 5", fv - la); end
  endtask

  task automatic test_desc_signed();
    int fa, la, fv, lx;
    int ref_out[$];
    // Hand-derived order for 0x80,0x7F,0x00,0xFF descending signed.
    ref_sort('{128, 127, 0, 255}, 1'b1, 1'b1, ref_out);
    checks++;
    if (ref_out !== '{127, 0, 255, 128})
      begin errors++; $display("FAIL desc_signed_model: got %p expected 127 0 255 128", ref_out); end
    run_frame("desc_signed", 3, '{128, 127, 0, 255}, 1'b0, 1'b0, fa, la, fv, lx);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < NI; k++) begin
      for (int f = 0; f < 3; f++) begin
        int vals[$];
        int fa, la, fv, lx;
        vals = {};
        // Narrow value range on some frames to force equal words.
        for (int i = 0; i < NS[k]; i++)
          vals.push_back((f == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)));
        run_frame($sformatf("bp_i%0d_f%0d", k, f), k, vals, 1'b1, 1'b1, fa, la, fv, lx);
      end
    end
  endtask

  task automatic test_reset_mid_sort();
    int fa, la, fv, lx, tmo;
    load_frame(0, '{200, 17, 99, 3}, fa, la, tmo);
    step();
    step();
    step();
    checks++;
    if (busy_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0)
      begin errors++; $display("FAIL midsort_state: got busy=%b rdy=%b expected busy=1 rdy=0",
        busy_w[0], in_ready_w[0]); end
    rst = 1'b1;
    step();
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || out_last_w[0] !== 1'b0 ||
        out_data_w[0] !== 8'h00 || busy_w[0] !== 1'b0)
      begin errors++; $display("FAIL midsort_reset: got rdy=%b vld=%b last=%b data=%0d busy=%b expected 1 0 0 0 0",
        in_ready_w[0], out_valid_w[0], out_last_w[0], out_data_w[0], busy_w[0]); end
    rst = 1'b0;
    step();
    run_frame("after_reset", 0, '{5, 6, 1, 0}, 1'b0, 1'b0, fa, la, fv, lx);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse8();
    test_odd5();
    test_desc_signed();
    test_backpressure();
    test_reset_mid_sort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
